// File: rtl/vector_store_serializer.sv
// Serializes one captured LANES x WORD_W vector into LANES single-word memory
// writes, highest lane first, with a ready/valid handshake toward memory.
module vector_store_serializer #(
  parameter int WORD_W = 16,
  parameter int LANES  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [LANES-1:0][WORD_W-1:0]  input_data,
  input  logic                          mem_ready,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [WORD_W-1:0]             mem_wdata,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [IDX_W-1:0]            idx_nxt;
  logic [LANES-1:0][WORD_W-1:0] vec_q, vec_d;
  logic [ADDR_W-1:0]           base_q, base_d;
  logic                        we_q, we_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [WORD_W-1:0]           wdata_q, wdata_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  // Word idx of the burst carries lane LANES-1-idx, so a load from the same
  // base through the read collector restores the original lane order.
  function automatic logic [IDX_W-1:0] lane_sel(input logic [IDX_W-1:0] i);
    return LAST_IDX - i;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    base_d  = base_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_nxt = idx_q + IDX_W'(1);

    case (state_q)
      S_IDLE: begin
        we_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_WRITE;
          vec_d   = input_data;
          base_d  = base_addr;
          idx_d   = '0;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          addr_d  = base_addr;
          wdata_d = input_data[LAST_IDX];
        end
      end
      S_WRITE: begin
        // Without mem_ready everything holds, keeping the request stable.
        if (mem_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_nxt;
            addr_d  = base_q + ADDR_W'(idx_nxt);
            wdata_d = vec_q[lane_sel(idx_nxt)];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      base_q  <= base_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vector_store_serializer.sv
// Directed bench for vector_store_serializer: stimulus pushes expected writes
// into a queue, a negedge monitor pops and compares each accepted write.
module tb_vector_store_serializer;

  typedef logic [15:0][15:0] vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  vec_t        input_data;
  logic        mem_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  vector_store_serializer #(
    .WORD_W(16),
    .LANES (16),
    .ADDR_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .input_data(input_data),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkvec(input logic [15:0] b);
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = b + 16'(i);
    return v;
  endfunction

  // Monitor: accepted writes pop the scoreboard, stalled writes must hold the head.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: got addr %h data %h with no write expected at %0t",
                 mem_addr, mem_wdata, $time);
      end else if (mem_ready) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("write_addr", {16'h0, mem_addr}, {16'h0, e[31:16]});
        chk("write_data", {16'h0, mem_wdata}, {16'h0, e[15:0]});
      end else begin
        chk("held_addr", {16'h0, mem_addr}, {16'h0, exp_q[0][31:16]});
        chk("held_data", {16'h0, mem_wdata}, {16'h0, exp_q[0][15:0]});
      end
    end
  end

  // Issue a start from IDLE; returns positioned in cycle 1 of the burst.
  task automatic start_burst(input logic [15:0] b, input vec_t v);
    start      = 1'b1;
    base_addr  = b;
    input_data = v;
    for (int k = 0; k < 16; k++) exp_q.push_back({b + 16'(k), v[15-k]});
    @(negedge clk);
    chk("idle_before_start", {30'h0, busy, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Walk cycles 1..done_c of a burst, stalling mem_ready in cycles s1/s2 and
  // pulsing an ignorable start in cycles i1/i2.
  task automatic observe(input int done_c, input int s1, input int s2,
                         input int i1, input int i2, input vec_t iv);
    for (int c = 1; c <= done_c; c++) begin
      mem_ready = !(c == s1 || c == s2);
      if (c == i1 || c == i2) begin
        start      = 1'b1;
        base_addr  = 16'h0200;
        input_data = iv;
      end else begin
        start = 1'b0;
        if (i1 != 0 && c > i1) input_data = {$urandom, $urandom, $urandom, $urandom,
                                             $urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      chk("busy", {31'h0, busy}, {31'h0, 1'b1});
      chk("done", {31'h0, done}, {31'h0, (c == done_c)});
      chk("mem_we", {31'h0, mem_we}, {31'h0, (c < done_c)});
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    mem_ready = 1'b1;
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = 16'h0;
    input_data = '0;
    mem_ready  = 1'b0;

    // Reset with random inputs and no start.
    for (int c = 0; c < 20; c++) begin
      base_addr  = 16'($urandom);
      input_data = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
      mem_ready  = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs", {mem_we, busy, done, mem_addr, mem_wdata}, 35'h0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {30'h0, busy, mem_we}, 32'h0);
    @(posedge clk);
    #1;

    // Basic burst.
    start_burst(16'h0100, mkvec(16'hA000));
    observe(17, 0, 0, 0, 0, '0);

    // Backpressure in WRITE cycles 3 and 4.
    start_burst(16'h0100, mkvec(16'hA000));
    observe(19, 3, 4, 0, 0, '0);

    // Address wrap.
    start_burst(16'hFFFE, mkvec(16'hA000));
    observe(17, 0, 0, 0, 0, '0);

    // Ignored starts in WRITE and DONE, input changes mid-burst.
    start_burst(16'h0100, mkvec(16'hA000));
    observe(17, 0, 0, 5, 17, mkvec(16'hB000));
    start_burst(16'h0200, mkvec(16'hC000));
    observe(17, 0, 0, 0, 0, '0);

    // Reset after the 5th accepted write.
    start_burst(16'h0300, mkvec(16'hD000));
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_outputs", {29'h0, mem_we, busy, done}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", {30'h0, mem_we, done}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_burst(16'h0300, mkvec(16'hE000));
    observe(17, 0, 0, 0, 0, '0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
